// File: rtl/seg7_pkg.sv
// Shared segment codes, display payload and the BCD-to-segment map for the scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // digit[3] is thousands, digit[0] is units; dp[i] belongs to digit[i]
  typedef struct packed {
    logic [3:0][3:0] digit;
    logic [3:0]      dp;
  } disp_t;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// Combinational BCD to active-low seven-segment decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  always_comb seg_c = bcd_to_seg(bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode multiplexed display driver with frame-synchronous
// double buffering and optional leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned DIGIT_HZ = 1_000,
  parameter int unsigned LZ_BLANK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  input  logic [3:0] dp_in,
  input  logic       load,
  input  logic       blank,
  output logic       pending,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned DIV   = CLK_HZ / DIGIT_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       idx;
  disp_t            staging;
  disp_t            shadow;
  disp_t            capture;
  logic             tick;
  logic             frame;
  logic [3:0]       vis;
  logic [3:0]       sel_digit;
  logic [6:0]       dec_seg_c;

  always_comb begin
    capture.digit = {digit3, digit2, digit1, digit0};
    capture.dp    = dp_in;
  end

  assign tick      = (div_cnt == CNT_W'(DIV - 1));
  assign frame     = tick && (idx == 2'd3);
  assign sel_digit = shadow.digit[idx];

  // A digit is visible once any digit at or above it is non-zero; units always shows
  always_comb begin
    vis = 4'b1111;
    if (LZ_BLANK != 0) begin
      vis[3] = |shadow.digit[3];
      vis[2] = vis[3] | (|shadow.digit[2]);
      vis[1] = vis[2] | (|shadow.digit[1]);
    end
  end

  seg7_decode u_decode (
    .bcd   (sel_digit),
    .seg_c (dec_seg_c)
  );

  // Scan timing, double buffer and registered pin drive
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= 2'd0;
      staging <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      an      <= 4'b1111;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
      if (tick) idx <= idx + 2'd1;

      // Boundary swap uses the old staging; a coincident load refills it and keeps pending
      if (frame && pending) begin
        shadow  <= staging;
        pending <= 1'b0;
      end
      if (load) begin
        staging <= capture;
        pending <= 1'b1;
      end

      if (vis[idx]) begin
        an  <= blank ? 4'b1111 : ~(4'b0001 << idx);
        seg <= dec_seg_c;
        dp  <= ~shadow.dp[idx];
      end else begin
        an  <= 4'b1111;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a frame-level display model.
module tb_seg7_scan_driver;

  localparam int unsigned CLK_HZ   = 8;
  localparam int unsigned DIGIT_HZ = 1;
  localparam int          DIV      = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit3 = '0, digit2 = '0, digit1 = '0, digit0 = '0;
  logic [3:0] dp_in = '0;
  logic       load = 1'b0;
  logic       blank = 1'b0;
  logic       pend0, pend1;
  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan_driver #(.CLK_HZ(CLK_HZ), .DIGIT_HZ(DIGIT_HZ), .LZ_BLANK(1)) u_dut_lz (
    .clk(clk), .rst_n(rst_n), .digit3(digit3), .digit2(digit2), .digit1(digit1),
    .digit0(digit0), .dp_in(dp_in), .load(load), .blank(blank),
    .pending(pend0), .an(an0), .seg(seg0), .dp(dp0)
  );

  seg7_scan_driver #(.CLK_HZ(CLK_HZ), .DIGIT_HZ(DIGIT_HZ), .LZ_BLANK(0)) u_dut_nolz (
    .clk(clk), .rst_n(rst_n), .digit3(digit3), .digit2(digit2), .digit1(digit1),
    .digit0(digit0), .dp_in(dp_in), .load(load), .blank(blank),
    .pending(pend1), .an(an1), .seg(seg1), .dp(dp1)
  );

  always #5 clk = ~clk;

  // Reference model: cycles since reset give the scanned position directly
  int         cyc;
  logic [3:0] st_d [4];
  logic [3:0] sh_d [4];
  logic [3:0] st_dp, sh_dp;
  bit         m_pend;
  logic [3:0] e_an  [2];
  logic [6:0] e_seg [2];
  logic       e_dp  [2];
  bit         e_segchk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  task automatic model_step();
    int  i, sum;
    bit  vis, frame;
    if (!rst_n) begin
      cyc = 0;
      for (int k = 0; k < 4; k++) begin st_d[k] = '0; sh_d[k] = '0; end
      st_dp = '0; sh_dp = '0; m_pend = 0;
      for (int m = 0; m < 2; m++) begin e_an[m] = 4'hF; e_seg[m] = 7'h7F; e_dp[m] = 1'b1; end
      e_segchk = 1;
    end else begin
      i = (cyc / DIV) % 4;
      sum = 0;
      for (int k = i; k < 4; k++) sum += int'(sh_d[k]);
      for (int m = 0; m < 2; m++) begin
        vis = (m == 1) || (i == 0) || (sum != 0);
        e_an[m] = 4'hF;
        if (vis && !blank) e_an[m][i] = 1'b0;
        e_seg[m] = vis ? seg_of(sh_d[i]) : 7'h7F;
        e_dp[m]  = vis ? ~sh_dp[i] : 1'b1;
      end
      e_segchk = !blank;
      frame = ((cyc % DIV) == DIV - 1) && (i == 3);
      if (frame && m_pend) begin
        sh_d = st_d; sh_dp = st_dp; m_pend = 0;
      end
      if (load) begin
        st_d[3] = digit3; st_d[2] = digit2; st_d[1] = digit1; st_d[0] = digit0;
        st_dp = dp_in; m_pend = 1;
      end
      cyc++;
    end
  endtask

  task automatic compare();
    chk("an_lz",        32'(an0),   32'(e_an[0]));
    chk("an_nolz",      32'(an1),   32'(e_an[1]));
    chk("pending_lz",   32'(pend0), 32'(m_pend));
    chk("pending_nolz", 32'(pend1), 32'(m_pend));
    if (e_segchk) begin
      chk("seg_lz",   32'(seg0), 32'(e_seg[0]));
      chk("seg_nolz", 32'(seg1), 32'(e_seg[1]));
      chk("dp_lz",    32'(dp0),  32'(e_dp[0]));
      chk("dp_nolz",  32'(dp1),  32'(e_dp[1]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] d, input logic [3:0] p);
    digit3 = a; digit2 = b; digit1 = c; digit0 = d; dp_in = p;
    load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  // Advance until the next posedge will be at the given position within a frame
  task automatic wait_phase(input int ph);
    for (int k = 0; k < 40; k++) begin
      if ((cyc % 32) == ph) break;
      cycle();
    end
    if ((cyc % 32) != ph) chk("wait_phase_timeout", 32'(cyc % 32), 32'(ph));
  endtask

  function automatic logic [3:0] rnd_digit();
    return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
  endfunction

  initial begin
    // Reset held with random inputs
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      digit3 = rnd_digit(); digit2 = rnd_digit(); digit1 = rnd_digit(); digit0 = rnd_digit();
      dp_in = 4'($urandom_range(0, 15)); load = 1'($urandom_range(0, 1)); blank = 1'($urandom_range(0, 1));
      cycle();
    end
    load = 1'b0; blank = 1'b0;
    rst_n = 1'b1;
    run(4);

    // 1234, then leading zeros with a decimal point
    do_load(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    run(70);
    do_load(4'd0, 4'd0, 4'd0, 4'd7, 4'b0001);
    run(70);

    // Mid-frame load is deferred; boundary-cycle load lands one frame late
    do_load(4'd1, 4'd2, 4'd3, 4'd4, 4'b0010);
    run(40);
    wait_phase(8);
    do_load(4'd5, 4'd6, 4'd7, 4'd8, 4'b0100);
    run(40);
    wait_phase(31);
    do_load(4'd9, 4'd0, 4'd1, 4'd2, 4'b1000);
    run(70);

    // Dash digit keeps lower zeros visible; global blank while scanning
    do_load(4'd0, 4'hA, 4'd0, 4'd0, 4'b0000);
    run(40);
    blank = 1'b1;
    run(20);
    blank = 1'b0;
    run(20);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      digit3 = rnd_digit(); digit2 = rnd_digit(); digit1 = rnd_digit(); digit0 = rnd_digit();
      dp_in = 4'($urandom_range(0, 15));
      load  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) blank = ~blank;
      cycle();
    end
    load = 1'b0; blank = 1'b0;
    run(10);

    // Reset in the middle of a scan with a capture pending
    wait_phase(0);
    do_load(4'd3, 4'd1, 4'd4, 4'd1, 4'b1111);
    wait_phase(16);
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Consumes the four BCD digits produced by the binary-to-decimal splitter (out3..out0, thousands..units) and drives a 4-digit, common-anode, time-multiplexed seven-segment display. The block has a refresh divider, a digit-scan counter, a double-buffered digit store that only updates on frame boundaries (no tearing), leading-zero blanking and a segment decoder. Its outputs go straight to the board pins.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz.
DIGIT_HZ, 1_000, per-digit dwell rate. DIV = CLK_HZ/DIGIT_HZ, and DIV must be >= 2.
LZ_BLANK, 1, 1 enables leading-zero blanking; 0 shows all four digits.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  synchronous, active-low reset.
digit3  input  4  thousands BCD digit.
digit2  input  4  hundreds BCD digit.
digit1  input  4  tens BCD digit.
digit0  input  4  units BCD digit.
dp_in  input  4  decimal-point enables; bit i belongs to digit i (1 = lit).
load  input  1  one-cycle strobe that captures digit3..0 and dp_in.
blank  input  1  level; 1 turns off all anodes.
pending  output  1  a capture is waiting for the next frame boundary.
an  output  4  anode enables, active-low; an[i] selects digit i (an[0] is the rightmost digit).
seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
dp  output  1  decimal-point cathode, active-low.

Behaviour:
- Reset (rst_n=0 at a rising edge) forces: div_cnt=0, idx=0, staging=0, shadow=0, pending=0, an=4'b1111, seg=7'h7F, dp=1. Reset has priority over every other input. A reset mid-scan restarts at idx=0 with a blank display.
- Divider: div_cnt counts 0..DIV-1 and wraps. tick=1 when div_cnt==DIV-1.
- Scan: on tick, idx advances 0→1→2→3→0. A frame boundary is a tick with idx==3.
- Load:
  - load=1 copies the inputs into staging and sets pending.
  - On a frame boundary with pending=1, staging is copied to shadow and pending clears.
  - A load in the same cycle as a frame boundary: the new inputs go to staging and pending stays 1. They are displayed one frame later.
  - Repeated loads while pending overwrite staging; the last one wins.
- Outputs are registered and are computed from the current idx and shadow, so they change one cycle after idx changes.
  - an = ~(4'b0001<<idx), or 4'b1111 when blank=1 or the selected digit is blanked.
  - Scanning continues while blank=1.
- Leading-zero blanking (LZ_BLANK=1):
  - d3 is blanked if d3==0.
  - d2 is blanked if d3==0 and d2==0.
  - d1 is blanked if d3, d2 and d1 are all 0.
  - d0 is never blanked.
  - A blanked digit forces seg=7'h7F and dp=1, and its anode stays off.
- Decoding (active-low, {g..a}):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10.
  - Codes 10–15 show a dash, 3F. For blanking purposes these count as non-zero.
- dp = ~shadow_dp[idx] for a visible digit.
- Widths: div_cnt is $clog2(DIV) bits and idx is 2 bits; both wrap naturally.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
  - A function bcd_to_seg(input [3:0]) returning [6:0].
- One sub-module is natural: seg7_decode (combinational BCD → segments). It is instantiated once, on the selected shadow digit.

Test Plan:
Every scenario uses CLK_HZ=8 and DIGIT_HZ=1, so DIV=8.
- Reset: hold rst_n=0 for 3 cycles with random inputs → an=1111, seg=7F, dp=1, pending=0. Release → an=1110 one cycle later, seg=40 (shadow is 0, d0 visible).
- Display 1234: load 1,2,3,4 → pending=1 until the first idx 3→0 tick. Then, every 8 cycles, the (an, seg) sequence is (1110,19), (1101,30), (1011,24), (0111,79), and it repeats.
- Leading zeros: load 0,0,0,7 with dp_in=0001 → an=1110 with seg=78 and dp=0; the other three slots have an=1111. With LZ_BLANK=0 the display shows 40,40,40,78.
- Deferred load: shadow=1234; at idx=1, load 5678 → the current frame still shows 1234 and the next frame shows 5678. A load asserted on the boundary cycle appears one frame late.
- Invalid digit and blank: load 0,A,0,0 → d2 shows 3F and d1 shows 40 (not blanked, because d2≠0). Set blank=1 → an=1111 within 1 cycle while idx keeps advancing.
- Mid-scan reset: assert rst_n=0 at idx=2 with pending=1 → the all-off reset state. After release, pending=0 and the display shows shadow=0.
